// File: rtl/clkpulsegen_multi.sv
// Multi-channel clock divider: each channel emits a one-cycle tick (PULSE) or a
// toggled level (SQUARE) every div[i] enabled cycles of clk.
module clkpulsegen_multi #(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = 26,
  parameter int unsigned DEF_DIV = 50000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           en,
  input  logic                     sync,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]         cfg_div,
  input  logic                     cfg_mode,
  output logic [NCH-1:0]           pulse,
  output logic [NCH-1:0]           busy
);

  localparam int               CH_W      = $clog2(NCH);
  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             MODE_SQUARE = 1'b1;

  logic [CNT_W-1:0] div_q [NCH];
  logic [CNT_W-1:0] div_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   mode_q;
  logic [NCH-1:0]   mode_d;
  logic [NCH-1:0]   pulse_q;
  logic [NCH-1:0]   pulse_d;
  logic [NCH-1:0]   busy_q;
  logic [NCH-1:0]   busy_d;

  // Per-channel next state; a config write to a channel outranks sync, idle and terminal count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      div_d[i]   = div_q[i];
      mode_d[i]  = mode_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = pulse_q[i];
      busy_d[i]  = en[i] && (div_q[i] != CNT_ZERO);
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        mode_d[i]  = cfg_mode;
        cnt_d[i]   = CNT_ZERO;
        pulse_d[i] = 1'b0;
      end else if (sync) begin
        cnt_d[i]   = CNT_ZERO;
        pulse_d[i] = 1'b0;
      end else if (!en[i] || (div_q[i] == CNT_ZERO)) begin
        cnt_d[i]   = CNT_ZERO;
        pulse_d[i] = 1'b0;
      end else if (cnt_q[i] == (div_q[i] - CNT_ONE)) begin
        cnt_d[i] = CNT_ZERO;
        if (mode_q[i] == MODE_SQUARE) begin
          pulse_d[i] = ~pulse_q[i];
        end else begin
          pulse_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
        if (mode_q[i] == MODE_SQUARE) begin
          pulse_d[i] = pulse_q[i];
        end else begin
          pulse_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= DEF_DIV_C;
        cnt_q[i] <= CNT_ZERO;
      end
      mode_q  <= {NCH{1'b0}};
      pulse_q <= {NCH{1'b0}};
      busy_q  <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_clkpulsegen_multi.sv
// Self-checking bench for clkpulsegen_multi: hand-derived vector table, directed
// corner sequences and a randomized run against a run-length reference model.
module tb_clkpulsegen_multi;

  localparam int NCH     = 4;
  localparam int CNT_W   = 26;
  localparam int DEF_DIV = 7;
  localparam int CH_W    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [NCH-1:0]   pulse;
  logic [NCH-1:0]   busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel tracks how many consecutive enabled edges it has
  // run since its last restart; the output follows from that run length alone.
  int unsigned    div_m  [NCH];
  bit             mode_m [NCH];
  longint         run_m  [NCH];
  logic [NCH-1:0] pulse_m;
  logic [NCH-1:0] busy_m;

  typedef struct {
    logic             r;
    logic [NCH-1:0]   e;
    logic             s;
    logic             we;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] dv;
    logic             md;
    logic [NCH-1:0]   ep;
    logic [NCH-1:0]   eb;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  clkpulsegen_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .pulse(pulse), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        div_m[i] = DEF_DIV; mode_m[i] = 1'b0; run_m[i] = 0;
        pulse_m[i] = 1'b0;  busy_m[i] = 1'b0;
      end else begin
        busy_m[i] = en[i] && (div_m[i] != 0);
        if (cfg_we && (int'(cfg_ch) == i)) begin
          div_m[i] = cfg_div; mode_m[i] = cfg_mode; run_m[i] = 0; pulse_m[i] = 1'b0;
        end else if (sync || !en[i] || (div_m[i] == 0)) begin
          run_m[i] = 0; pulse_m[i] = 1'b0;
        end else begin
          run_m[i]++;
          if (mode_m[i]) pulse_m[i] = ((run_m[i] / div_m[i]) % 2) == 1;
          else           pulse_m[i] = (run_m[i] % div_m[i]) == 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] e, input logic s, input logic we,
                      input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
    rst = r; en = e; sync = s; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
    model_edge();
    @(posedge clk);
    #1;
    check("pulse_vs_model", 32'(pulse), 32'(pulse_m));
    check("busy_vs_model", 32'(busy), 32'(busy_m));
  endtask

  task automatic run(input logic [NCH-1:0] e);
    step(1'b0, e, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0);
  endtask

  initial begin
    // Reset, ch0 PULSE div=4, then ch1 SQUARE div=3 alongside it.
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0000});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 26'd2, 1'b0, 4'b0000, 4'b0000});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 26'd4, 1'b0, 4'b0000, 4'b0000});
    for (int j = 0; j < 3; j++)
      tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0001, 4'b0001});
    for (int j = 0; j < 3; j++)
      tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0001, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 1'b1, 2'd1, 26'd3, 1'b1, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0011, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0010, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0010, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0001, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0000, 4'b0011});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, 4'b0010, 4'b0011});

    for (int j = 0; j < tbl.size(); j++) begin
      step(tbl[j].r, tbl[j].e, tbl[j].s, tbl[j].we, tbl[j].ch, tbl[j].dv, tbl[j].md);
      check($sformatf("tbl_pulse[%0d]", j), 32'(pulse), 32'(tbl[j].ep));
      check($sformatf("tbl_busy[%0d]", j), 32'(busy), 32'(tbl[j].eb));
    end

    // ch2 div=1 PULSE holds high, then div=0 idles it.
    step(1'b0, 4'b0011, 1'b0, 1'b1, 2'd2, 26'd1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      run(4'b0111);
      check("div1_pulse_high", 32'(pulse[2]), 32'd1);
    end
    step(1'b0, 4'b0111, 1'b0, 1'b1, 2'd2, 26'd0, 1'b0);
    check("div0_pulse_low", 32'(pulse[2]), 32'd0);
    run(4'b0111);
    check("div0_pulse_low2", 32'(pulse[2]), 32'd0);
    check("div0_busy_low", 32'(busy[2]), 32'd0);

    // ch0 div=10, rewritten to div=5 at cnt=7.
    step(1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 26'd10, 1'b0);
    for (int j = 0; j < 7; j++) run(4'b0001);
    step(1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 26'd5, 1'b0);
    check("rewrite_no_tick", 32'(pulse[0]), 32'd0);
    for (int j = 1; j <= 5; j++) begin
      run(4'b0001);
      check($sformatf("rewrite_tick_j%0d", j), 32'(pulse[0]), 32'(j == 5));
    end

    // ch0 div=4 and ch3 div=6 out of phase, then sync.
    step(1'b0, 4'b1001, 1'b0, 1'b1, 2'd0, 26'd4, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 1'b1, 2'd3, 26'd6, 1'b0);
    for (int j = 0; j < 5; j++) run(4'b1001);
    step(1'b0, 4'b1001, 1'b1, 1'b0, 2'd0, 26'd0, 1'b0);
    check("sync_clears", 32'(pulse), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      run(4'b1001);
      check($sformatf("sync_ch0_j%0d", j), 32'(pulse[0]), 32'((j % 4) == 0));
      check($sformatf("sync_ch3_j%0d", j), 32'(pulse[3]), 32'((j % 6) == 0));
    end

    // Reset mid-count with en high and a config write that must be ignored.
    for (int j = 0; j < 3; j++) run(4'b0001);
    for (int j = 0; j < 2; j++) begin
      step(1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 26'd2, 1'b1);
      check("rst_pulse", 32'(pulse), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    for (int j = 1; j <= 7; j++) begin
      run(4'b0001);
      check($sformatf("rst_defdiv_j%0d", j), 32'(pulse[0]), 32'(j == 7));
      check("rst_busy_after", 32'(busy[0]), 32'd1);
    end

    // Randomized traffic against the reference model.
    for (int j = 0; j < 3000; j++) begin
      step(($urandom_range(0, 199) == 0), NCH'($urandom), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 14) == 0), CH_W'($urandom), CNT_W'($urandom_range(0, 6)),
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
